// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality check for the single-clock FIFO.
package sync_fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers and count carry one extra bit so that "full" and "empty" stay distinguishable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit thresh_legal(input int addr_width, input int afull, input int aempty);
        return (afull >= 1) && (afull <= fifo_depth(addr_width)) &&
               (aempty >= 0) && (aempty < fifo_depth(addr_width));
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int DATAWIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0]  rdata
);

    logic [DATAWIDTH-1:0] mem [1 << ADDR_WIDTH];

    // NOTE: the array has no reset; stale words are never visible because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and sticky error bits.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is a registered rdata.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATAWIDTH-1:0]               wdata,
    input  logic                               winc,
    input  logic                               rinc,
    input  logic                               err_clr,
    output logic [DATAWIDTH-1:0]               rdata,
    output logic                               wfull,
    output logic                               rempty,
    output logic [count_width(ADDR_WIDTH)-1:0] count,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (!thresh_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo: AFULL_THRESH must be 1..DEPTH and AEMPTY_THRESH 0..DEPTH-1");
    end

    logic [CW-1:0]        wptr;
    logic [CW-1:0]        rptr;
    logic [CW-1:0]        count_next;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic                 wr_en;
    logic                 rd_en;

    assign wr_en = winc && !wfull;
    assign rd_en = rinc && !rempty;

    sync_fifo_mem #(
        .DATAWIDTH  (DATAWIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // NOTE: count_next gets its default first so no path through this block can infer a latch.
    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are registered from count_next so they move on the same edge as the accepted op.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            count        <= count_next;
            wfull        <= (count_next == DEPTH_C);
            rempty       <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
        end
    end

    // Setting an error takes priority over clearing it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)   overflow <= 1'b1;
            else if (err_clr)    overflow <= 1'b0;
            if (rinc && rempty)  underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_rdata;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo; runs in both registered and FWFT builds.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] wdata;
    logic          winc;
    logic          rinc;
    logic          err_clr;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          rempty;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DATAWIDTH     (DW),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (6),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wdata        (wdata),
        .winc         (winc),
        .rinc         (rinc),
        .err_clr      (err_clr),
        .rdata        (rdata),
        .wfull        (wfull),
        .rempty       (rempty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge act, sample at the next falling edge.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] wd,
                        input logic rd, input logic clr);
        rst     = r;
        winc    = w;
        wdata   = wd;
        rinc    = rd;
        err_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_rdata_reg(input string tag, input logic [DW-1:0] expected);
`ifndef SYNC_FIFO_FWFT_EN
        check(tag, 32'(rdata), 32'(expected));
`endif
    endtask

    task automatic check_rdata_fwft(input string tag, input logic [DW-1:0] expected);
`ifdef SYNC_FIFO_FWFT_EN
        check(tag, 32'(rdata), 32'(expected));
`endif
    endtask

    initial begin
        int exp_cnt;
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
        @(negedge clk);

        // 1. reset state
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_rempty", 32'(rempty), 1);
        check("rst_wfull", 32'(wfull), 0);
        check("rst_count", 32'(count), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check_rdata_reg("rst_rdata", 8'h00);

        // 2. fill past full: words 8 and 9 are dropped
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            exp_cnt = (i + 1 > 8) ? 8 : i + 1;
            check("fill_count", 32'(count), 32'(exp_cnt));
            check("fill_wfull", 32'(wfull), 32'(exp_cnt == 8));
            check("fill_afull", 32'(almost_full), 32'(exp_cnt >= 6));
            check("fill_rempty", 32'(rempty), 0);
            check("fill_ovf", 32'(overflow), 32'(i >= 8));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);
        check("ovf_clr_count", 32'(count), 8);

        // 3. drain past empty
        for (int i = 0; i < 10; i++) begin
            if (i < 8) check_rdata_fwft("drain_fwft", 8'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            exp_cnt = (i < 8) ? 7 - i : 0;
            check_rdata_reg("drain_rdata", 8'((i < 8) ? i : 7));
            check("drain_count", 32'(count), 32'(exp_cnt));
            check("drain_rempty", 32'(rempty), 32'(exp_cnt == 0));
            check("drain_aempty", 32'(almost_empty), 32'(exp_cnt <= 1));
            check("drain_unf", 32'(underflow), 32'(i >= 8));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 0);

        // 4. preload 4, then stream with simultaneous write/read across two pointer wraps
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("pre_count", 32'(count), 4);
        for (int i = 0; i < 20; i++) begin
            check_rdata_fwft("stream_fwft", 8'(8'h10 + i));
            step(1'b0, 1'b1, 8'(8'h14 + i), 1'b1, 1'b0);
            check_rdata_reg("stream_rdata", 8'(8'h10 + i));
            check("stream_count", 32'(count), 4);
        end
        check("stream_ovf", 32'(overflow), 0);
        check("stream_unf", 32'(underflow), 0);

        // 5a. full plus simultaneous write/read: write dropped, read accepted
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h28 + i), 1'b0, 1'b0);
        check("full_wfull", 32'(wfull), 1);
        check_rdata_fwft("full_wr_fwft", 8'h24);
        step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_wr_count", 32'(count), 7);
        check("full_wr_wfull", 32'(wfull), 0);
        check("full_wr_ovf", 32'(overflow), 1);
        check_rdata_reg("full_wr_rdata", 8'h24);
        for (int j = 0; j < 7; j++) begin
            check_rdata_fwft("full_drain_fwft", 8'(8'h25 + j));
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check_rdata_reg("full_drain_rdata", 8'(8'h25 + j));
        end
        check("full_drain_rempty", 32'(rempty), 1);

        // 5b. empty plus simultaneous write/read: write accepted, read dropped
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
        check("empty_wr_count", 32'(count), 1);
        check("empty_wr_unf", 32'(underflow), 1);
        check("empty_wr_rempty", 32'(rempty), 0);
        check_rdata_reg("empty_wr_hold", 8'h2B);
        check_rdata_fwft("empty_wr_fwft", 8'h5C);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_rdata_reg("empty_wr_rdata", 8'h5C);
        check("empty_wr_count2", 32'(count), 0);

        // 6. reset mid-operation discards contents
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check("mid_count", 32'(count), 5);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_rempty", 32'(rempty), 1);
        check("mid_rst_aempty", 32'(almost_empty), 1);
        check_rdata_reg("mid_rst_rdata", 8'h00);
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 1);
        check("post_rst_rempty", 32'(rempty), 0);
        check_rdata_fwft("post_rst_fwft", 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_rdata_reg("post_rst_rdata", 8'hA5);
        check("post_rst_empty", 32'(rempty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
